// File: rtl/branch_ckpt_ctrl.sv
// Branch checkpoint controller: orders live free-list snapshots and sequences mispredict recovery.
// Optional statistics counters are compiled in with `define BRCKPT_STATS_EN.
module branch_ckpt_ctrl #(
  parameter int ROB_WIDTH     = 4,
  parameter int MAX_BR        = 4,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      br_dispatch_req,
  input  logic [ROB_WIDTH-1:0]      br_dispatch_tag,
  output logic                      br_dispatch_ready,
  output logic                      fl_is_branch_dispatch,
  output logic [ROB_WIDTH-1:0]      fl_dispatch_tag,
  input  logic                      resolve_valid,
  input  logic [ROB_WIDTH-1:0]      resolve_tag,
  input  logic                      resolve_mispredict,
  output logic                      resolve_ready,
  output logic                      fl_branch_mispredict,
  output logic [ROB_WIDTH-1:0]      fl_recovery_tag,
  input  logic                      flush_valid,
  output logic                      recovery_busy,
  output logic [$clog2(MAX_BR):0]   ckpt_count,
  output logic                      resolve_unknown,
  output logic [15:0]               stat_mispredicts,
  output logic [15:0]               stat_stall_cycles
);

  localparam int IW  = $clog2(MAX_BR);
  localparam int PW  = IW + 1;
  localparam int SCW = (SETTLE_CYCLES > 3) ? $clog2(SETTLE_CYCLES + 1) : 2;

  typedef enum logic [1:0] {IDLE, RESTORE, SETTLE} state_e;

  state_e               state_q, state_d;
  logic [SCW-1:0]       settle_q, settle_d;
  logic [PW-1:0]        head_q, head_d, tail_q, tail_d;
  logic [ROB_WIDTH-1:0] rec_tag_q, rec_tag_d;
  logic                 unk_q, unk_d;
  logic [ROB_WIDTH-1:0] tag_q [MAX_BR];
  logic                 res_q [MAX_BR];

  logic [PW-1:0] count;
  logic          idle, hit, hit_resolved, res_fire, push, pop, mp_take, ok_take;
  logic [IW-1:0] hit_idx, hit_off, off_v;
  logic [PW-1:0] hit_ptr;

  assign count = tail_q - head_q;
  assign idle  = (state_q == IDLE);

  // A slot is live when its distance from head (mod depth) is below the count.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    hit_off = '0;
    off_v   = '0;
    for (int i = 0; i < MAX_BR; i++) begin
      off_v = IW'(i) - head_q[IW-1:0];
      if (!hit && ({1'b0, off_v} < count) && (tag_q[i] == resolve_tag)) begin
        hit     = 1'b1;
        hit_idx = IW'(i);
        hit_off = off_v;
      end
    end
  end

  assign hit_ptr      = head_q + {1'b0, hit_off};
  assign hit_resolved = res_q[hit_idx];

  assign resolve_ready     = idle && !flush_valid;
  assign br_dispatch_ready = idle && (count < PW'(MAX_BR)) &&
                             !(resolve_valid && resolve_mispredict && hit) && !flush_valid;
  assign fl_is_branch_dispatch = br_dispatch_req && br_dispatch_ready;
  assign fl_dispatch_tag       = br_dispatch_tag;

  assign res_fire = resolve_valid && resolve_ready;
  assign push     = fl_is_branch_dispatch;
  assign pop      = (count != '0) && res_q[head_q[IW-1:0]];
  assign mp_take  = res_fire && resolve_mispredict && hit && !hit_resolved;
  assign ok_take  = res_fire && !resolve_mispredict && hit;
  assign unk_d    = res_fire && (!hit || (resolve_mispredict && hit_resolved));

  assign head_d = head_q + PW'(pop);
  assign tail_d = mp_take ? hit_ptr : tail_q + PW'(push);

  always_comb begin
    state_d   = state_q;
    settle_d  = settle_q;
    rec_tag_d = rec_tag_q;
    case (state_q)
      IDLE: begin
        if (mp_take) begin
          state_d   = RESTORE;
          rec_tag_d = resolve_tag;
        end
      end
      RESTORE: begin
        settle_d = SCW'(SETTLE_CYCLES);
        state_d  = SETTLE;
      end
      SETTLE: begin
        if (settle_q <= SCW'(1)) begin
          settle_d = '0;
          state_d  = IDLE;
        end else begin
          settle_d = settle_q - SCW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || flush_valid) begin
      state_q  <= IDLE;
      settle_q <= '0;
      head_q   <= '0;
      tail_q   <= '0;
      unk_q    <= 1'b0;
      if (reset) rec_tag_q <= '0;
    end else begin
      state_q   <= state_d;
      settle_q  <= settle_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      rec_tag_q <= rec_tag_d;
      unk_q     <= unk_d;
    end
  end

  // Push slot is never live (not full), so it cannot collide with a resolve write.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < MAX_BR; i++) begin
        tag_q[i] <= '0;
        res_q[i] <= 1'b0;
      end
    end else if (!flush_valid) begin
      if (push) begin
        tag_q[tail_q[IW-1:0]] <= br_dispatch_tag;
        res_q[tail_q[IW-1:0]] <= 1'b0;
      end
      if (ok_take) res_q[hit_idx] <= 1'b1;
    end
  end

  assign fl_branch_mispredict = (state_q == RESTORE) && !flush_valid;
  assign fl_recovery_tag      = fl_branch_mispredict ? rec_tag_q : '0;
  assign recovery_busy        = !idle;
  assign ckpt_count           = count;
  assign resolve_unknown      = unk_q;

`ifdef BRCKPT_STATS_EN
  logic [15:0] stat_mp_q, stat_st_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_mp_q <= '0;
      stat_st_q <= '0;
    end else begin
      if (mp_take && (stat_mp_q != 16'hFFFF)) stat_mp_q <= stat_mp_q + 16'd1;
      if (br_dispatch_req && !br_dispatch_ready && (stat_st_q != 16'hFFFF))
        stat_st_q <= stat_st_q + 16'd1;
    end
  end

  assign stat_mispredicts  = stat_mp_q;
  assign stat_stall_cycles = stat_st_q;
`else
  assign stat_mispredicts  = 16'd0;
  assign stat_stall_cycles = 16'd0;
`endif

endmodule

// File: tb/tb_branch_ckpt_ctrl.sv
// Directed plus random bench for branch_ckpt_ctrl against a queue-based checkpoint model.
module tb_branch_ckpt_ctrl;
  localparam int RW = 4;
  localparam int MAX_BR = 4;
  localparam int S = 2;

  logic clk = 1'b0;
  logic reset, req, rv, rm, flush;
  logic [RW-1:0] dtag, rtag;
  logic d_ready, fl_disp, r_ready, fl_mp, busy, unk;
  logic [RW-1:0] fl_dtag, fl_rtag;
  logic [$clog2(MAX_BR):0] cnt;
  logic [15:0] st_mp, st_st;

  always #5 clk = ~clk;

  branch_ckpt_ctrl #(.ROB_WIDTH(RW), .MAX_BR(MAX_BR), .SETTLE_CYCLES(S)) dut (
    .clk(clk), .reset(reset),
    .br_dispatch_req(req), .br_dispatch_tag(dtag), .br_dispatch_ready(d_ready),
    .fl_is_branch_dispatch(fl_disp), .fl_dispatch_tag(fl_dtag),
    .resolve_valid(rv), .resolve_tag(rtag), .resolve_mispredict(rm), .resolve_ready(r_ready),
    .fl_branch_mispredict(fl_mp), .fl_recovery_tag(fl_rtag),
    .flush_valid(flush), .recovery_busy(busy), .ckpt_count(cnt),
    .resolve_unknown(unk), .stat_mispredicts(st_mp), .stat_stall_cycles(st_st));

  typedef struct { logic [RW-1:0] tag; bit res; } ent_t;
  ent_t mq[$];
  int blk, m_mp, m_st, hit_pos, n_tests, n_fail, cyc;
  bit m_unk, e_idle, e_dready, e_rready, e_pulse;
  logic [RW-1:0] m_rec;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic calc();
    hit_pos = -1;
    foreach (mq[i]) if (mq[i].tag == rtag) hit_pos = i;
    e_idle   = (blk == 0);
    e_rready = e_idle && !flush;
    e_dready = e_idle && (mq.size() < MAX_BR) && !(rv && rm && hit_pos >= 0) && !flush;
    e_pulse  = (blk == 1 + S) && !flush;
  endtask

  task automatic model_step();
    bit consumed, mp, popnow, nunk;
    if (reset) begin
      mq.delete(); blk = 0; m_unk = 0; m_mp = 0; m_st = 0;
    end else begin
      if (req && !e_dready && m_st < 16'hFFFF) m_st++;
      if (flush) begin
        mq.delete(); blk = 0; m_unk = 0;
      end else begin
        consumed = rv && e_rready;
        nunk   = consumed && (hit_pos < 0 || (rm && mq[hit_pos].res));
        mp     = consumed && rm && hit_pos >= 0 && !mq[hit_pos].res;
        popnow = mq.size() > 0 && mq[0].res;
        if (mp) begin
          while (mq.size() > hit_pos) mq.delete(mq.size() - 1);
          m_rec = rtag;
          if (m_mp < 16'hFFFF) m_mp++;
        end else if (consumed && !rm && hit_pos >= 0) begin
          mq[hit_pos].res = 1;
        end
        if (popnow) mq.delete(0);
        if (req && e_dready) mq.push_back('{dtag, 1'b0});
        if (blk > 0) blk--;
        if (mp) blk = 1 + S;
        m_unk = nunk;
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    calc();
    chk("ckpt_count", 32'(cnt), 32'(mq.size()));
    chk("dispatch_ready", 32'(d_ready), 32'(e_dready));
    chk("resolve_ready", 32'(r_ready), 32'(e_rready));
    chk("fl_is_branch_dispatch", 32'(fl_disp), 32'(req && e_dready));
    chk("fl_dispatch_tag", 32'(fl_dtag), 32'(dtag));
    chk("fl_branch_mispredict", 32'(fl_mp), 32'(e_pulse));
    if (e_pulse) chk("fl_recovery_tag", 32'(fl_rtag), 32'(m_rec));
    chk("recovery_busy", 32'(busy), 32'(!e_idle));
    chk("resolve_unknown", 32'(unk), 32'(m_unk));
`ifdef BRCKPT_STATS_EN
    chk("stat_mispredicts", 32'(st_mp), 32'(m_mp));
    chk("stat_stall_cycles", 32'(st_st), 32'(m_st));
`else
    chk("stat_mispredicts", 32'(st_mp), 32'd0);
    chk("stat_stall_cycles", 32'(st_st), 32'd0);
`endif
    $display("[TB] cyc=%0d rst=%0b req=%0b dtag=%0d rv=%0b rtag=%0d mp=%0b fl=%0b | cnt=%0d rdy=%0b pulse=%0b unk=%0b",
             cyc, reset, req, dtag, rv, rtag, rm, flush, cnt, d_ready, fl_mp, unk);
    @(posedge clk);
    model_step();
    cyc++;
    #1;
  endtask

  task automatic quiet();
    reset = 0; req = 0; dtag = '0; rv = 0; rtag = '0; rm = 0; flush = 0;
  endtask

  task automatic disp(input int t);
    quiet(); req = 1; dtag = RW'(t); cycle();
  endtask

  task automatic resolve(input int t, input bit misp);
    quiet(); rv = 1; rtag = RW'(t); rm = misp; cycle();
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) begin quiet(); cycle(); end
  endtask

  task automatic do_flush();
    quiet(); flush = 1; cycle();
  endtask

  function automatic bit in_q(input logic [RW-1:0] t);
    foreach (mq[i]) if (mq[i].tag == t) return 1;
    return 0;
  endfunction

  initial begin
    n_tests = 0; n_fail = 0; cyc = 0; blk = 0; m_unk = 0; m_mp = 0; m_st = 0; m_rec = '0;
    quiet(); reset = 1;
    @(posedge clk); model_step(); #1;
    cycle(); cycle();
    idle_n(1);
    // Fill to capacity, then a fifth request must stall
    disp(3); disp(5); disp(7); disp(9); disp(11);
    do_flush();
    // In-order retire of correctly predicted branches
    disp(3); disp(5); disp(7);
    resolve(5, 0); resolve(3, 0); idle_n(3);
    do_flush();
    // Mispredict with younger squash and settle window
    disp(3); disp(5); disp(7); disp(9);
    resolve(5, 1); idle_n(5);
    // Mispredict collides with a dispatch
    quiet(); rv = 1; rtag = 4'd3; rm = 1; req = 1; dtag = 4'd11; cycle();
    idle_n(5);
    // Unknown tag, then mispredict of an already-resolved entry
    resolve(12, 0); idle_n(2);
    disp(6); disp(8); resolve(8, 0); resolve(8, 1); idle_n(2);
    do_flush();
    // Flush during SETTLE
    disp(3); disp(5); resolve(5, 1); idle_n(2); do_flush(); idle_n(3);
    // Reset during RESTORE
    disp(3); disp(5); resolve(5, 1);
    quiet(); reset = 1; cycle();
    idle_n(3);
    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      quiet();
      if ($urandom_range(0, 99) < 60) begin
        dtag = RW'($urandom_range(0, 15));
        req = !in_q(dtag);
      end
      if ($urandom_range(0, 99) < 45) begin
        rv = 1;
        rm = ($urandom_range(0, 99) < 25);
        if (mq.size() > 0 && $urandom_range(0, 99) < 80)
          rtag = mq[$urandom_range(0, mq.size() - 1)].tag;
        else
          rtag = RW'($urandom_range(0, 15));
      end
      flush = ($urandom_range(0, 99) < 2);
      reset = ($urandom_range(0, 999) < 5);
      cycle();
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_ckpt_ctrl.md
Name: branch_ckpt_ctrl

Overview:
Controller for the free list's head-pointer snapshots.
- Admits branch dispatches and drives the free list's snapshot-write port.
- Tracks live checkpoints in program order.
- Sequences misprediction recovery: single-cycle restore pulse, younger checkpoints squashed, dispatch/resolve stalled during a settle window.
- Sits between rename/dispatch, branch resolution and free_list.

Parameters:
ROB_WIDTH, 4, width of branch ROB tags; must match free_list.ROB_WIDTH
MAX_BR, 4, max outstanding checkpoints (FIFO depth, power of 2, 2..16)
SETTLE_CYCLES, 2, stall cycles after restore pulse (>=1)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
br_dispatch_req  in  1  rename wants to dispatch a branch this cycle
br_dispatch_tag  in  ROB_WIDTH  ROB tag of that branch
br_dispatch_ready  out  1  branch accepted when req&&ready
fl_is_branch_dispatch  out  1  to free_list.is_branch_dispatch
fl_dispatch_tag  out  ROB_WIDTH  to free_list.dispatch_tag
resolve_valid  in  1  a branch resolves this cycle
resolve_tag  in  ROB_WIDTH  tag of resolving branch
resolve_mispredict  in  1  1 = mispredicted, 0 = correct
resolve_ready  out  1  resolve consumed when valid&&ready
fl_branch_mispredict  out  1  to free_list.branch_mispredict
fl_recovery_tag  out  ROB_WIDTH  to free_list.recovery_tag
flush_valid  in  1  full pipeline flush; drops all checkpoints
recovery_busy  out  1  FSM not IDLE
ckpt_count  out  $clog2(MAX_BR)+1  live checkpoint count
resolve_unknown  out  1  registered 1-cycle pulse: bad resolve
stat_mispredicts  out  16  mispredict counter (optional feature)
stat_stall_cycles  out  16  dispatch-stall counter (optional feature)

Behaviour:
- Storage: circular FIFO of MAX_BR entries {tag, resolved}. Head/tail pointers are $clog2(MAX_BR)+1 bits; wrap bit distinguishes full from empty. ckpt_count = tail - head.
- FSM states IDLE, RESTORE, SETTLE; 2-bit settle counter register.
- br_dispatch_ready = IDLE && count<MAX_BR && !(resolve_valid && resolve_mispredict && hit) && !flush_valid. Combinational.
- fl_is_branch_dispatch = br_dispatch_req && br_dispatch_ready; fl_dispatch_tag = br_dispatch_tag. Both combinational, same cycle. On accept, push {tag,0} at tail.
- resolve_ready = IDLE && !flush_valid.
- Hit: resolve_tag equals a live entry's tag (head <= pos < tail). Dispatch tags are unique among live entries.
- Correct resolve with hit: set that entry's resolved bit.
- Each cycle, if count>0 and head entry resolved: pop one (head+1). Pop, push and resolve may all occur in the same cycle.
- Mispredict resolve with hit on an unresolved entry at pos:
  - next cycle tail <= pos, squashing it and all younger;
  - latch tag; FSM -> RESTORE.
- RESTORE: fl_branch_mispredict=1 and fl_recovery_tag=latched tag, for exactly one cycle. Settle counter loads SETTLE_CYCLES. -> SETTLE.
- SETTLE: counter decrements each cycle; -> IDLE in the cycle it reaches 1. Dispatch and resolves blocked; head popping continues.
- Restore-pulse to next-dispatch latency = 1 + SETTLE_CYCLES cycles.
- resolve_unknown pulses one cycle after a consumed resolve that:
  - misses, or
  - is a mispredict on an already-resolved entry.
  No other state change.
- flush_valid (priority below reset, above all else): head=tail=0, FSM->IDLE, fl_branch_mispredict held 0 that cycle. An in-flight RESTORE pulse is suppressed.
- Reset, including mid-recovery: FIFO empty, FSM IDLE. All outputs 0 except br_dispatch_ready=1 and resolve_ready=1 once reset deasserts. Stats = 0.

Optional Feature:
Macro BRCKPT_STATS_EN.
- Defined:
  - stat_mispredicts increments on each RESTORE entry.
  - stat_stall_cycles increments each cycle br_dispatch_req=1 && br_dispatch_ready=0.
  - Both 16-bit, saturating at 0xFFFF; cleared by reset only (not flush).
- Undefined: both outputs tied to 0, no counter flops.

Test Plan:
- Reset, dispatch tags 3,5,7,9 in consecutive cycles -> fl_is_branch_dispatch high 4 cycles with matching tags; ckpt_count=4; a 5th req sees ready=0.
- Live 3,5,7; correct-resolve 5, then 3 -> entries pop at head one per cycle; count 3->2->1; 7 remains.
- Live 3,5,7,9; mispredict 5 -> next cycle fl_branch_mispredict=1 with fl_recovery_tag=5 for one cycle; count=1; dispatch/resolve ready low 1+2 cycles; stat_mispredicts=1 when enabled.
- Mispredict resolve and dispatch of tag 11 in the same cycle -> tag 11 not accepted, no fl_is_branch_dispatch; recovery proceeds.
- Resolve tag 12 (not live) -> resolve_unknown pulses one cycle later; count and FSM unchanged.
- flush_valid during SETTLE, and separately reset during RESTORE -> count=0, IDLE next cycle, no further mispredict pulse, ready=1.
